// File: rtl/ex_div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings,
// handshake levels and the ALU op codes that EX decodes into start/signed requests.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider serving DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} held with ready_o until EX drops start_i.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   dividend, dividend_nxt;
  logic [WIDTH-1:0]   divisor, divisor_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic               sign1, sign1_nxt;
  logic               sign2, sign2_nxt;
  logic               sgn, sgn_nxt;
  logic [2*WIDTH-1:0] result_nxt;
  logic               ready_nxt;

  logic [WIDTH:0]     partial, trial;
  logic               borrow;
  logic [WIDTH-1:0]   rem_step, quo_step, quo_fix, rem_fix;

  // Trial subtract is WIDTH+1 bits; since rem < divisor the MSB is a pure borrow flag.
  always_comb begin
    partial  = {rem, dividend[WIDTH-1]};
    trial    = partial - {1'b0, divisor};
    borrow   = trial[WIDTH];
    rem_step = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {dividend[WIDTH-2:0], ~borrow};
    quo_fix  = (sgn && (sign1 ^ sign2)) ? ('0 - quo_step) : quo_step;
    rem_fix  = (sgn && sign1) ? ('0 - rem_step) : rem_step;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    rem_nxt      = rem;
    sign1_nxt    = sign1;
    sign2_nxt    = sign2;
    sgn_nxt      = sgn;
    result_nxt   = result_o;
    ready_nxt    = ready_o;

    unique case (state)
      DIV_FREE: begin
        ready_nxt  = DIV_RESULT_NOT_READY;
        result_nxt = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DIV_BY_ZERO;
          end else begin
            state_nxt    = DIV_ON;
            cnt_nxt      = '0;
            rem_nxt      = '0;
            sgn_nxt      = signed_div_i;
            sign1_nxt    = opdata1_i[WIDTH-1];
            sign2_nxt    = opdata2_i[WIDTH-1];
            dividend_nxt = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
            divisor_nxt  = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
          end
        end
      end
      DIV_BY_ZERO: begin
        result_nxt = '0;
        if (annul_i) begin
          state_nxt = DIV_FREE;
          ready_nxt = DIV_RESULT_NOT_READY;
        end else begin
          state_nxt = DIV_END;
          ready_nxt = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt  = DIV_FREE;
          ready_nxt  = DIV_RESULT_NOT_READY;
          result_nxt = '0;
        end else begin
          rem_nxt      = rem_step;
          dividend_nxt = quo_step;
          cnt_nxt      = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nxt  = DIV_END;
            cnt_nxt    = '0;
            result_nxt = {rem_fix, quo_fix};
            ready_nxt  = DIV_RESULT_READY;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_nxt  = DIV_FREE;
          ready_nxt  = DIV_RESULT_NOT_READY;
          result_nxt = '0;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sgn      <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      rem      <= rem_nxt;
      sign1    <= sign1_nxt;
      sign2    <= sign2_nxt;
      sgn      <= sgn_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: table of divisions with hand-computed results and
// latencies, plus sequences for hold, annul, and asynchronous reset.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ex_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int unsigned lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Count edges from the one that samples start (edge 1); ready must appear exactly at edge lat.
  task automatic expect_ready_at(input int unsigned lat, input string name);
    logic early;
    early = 1'b0;
    for (int unsigned k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == 1 && lat > 2) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (k < lat && ready_o === 1'b1) early = 1'b1;
    end
    check({name, "_early_ready"}, {63'd0, early}, 64'd0);
    check({name, "_ready"}, {63'd0, ready_o}, 64'd1);
  endtask

  task automatic drop_and_check_idle(input string name);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, "_idle_ready"}, {63'd0, ready_o}, 64'd0);
    check({name, "_idle_result"}, result_o, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    expect_ready_at(v.lat, v.name);
    check({v.name, "_result"}, result_o, v.exp);
    drop_and_check_idle(v.name);
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},         33};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 33};
    vecs[3] = '{"div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,         32'h8000_0000}, 33};
    vecs[4] = '{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,         32'hFFFF_FFFF}, 33};
    vecs[5] = '{"div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},        33};
    vecs[6] = '{"divu_max_16",  1'b0, 32'hFFFF_FFFF,  32'd16,         {32'hF,         32'h0FFF_FFFF}, 33};
    vecs[7] = '{"div_by_zero",  1'b1, 32'hFFFF_FFF9,  32'd0,          64'd0,                          2};

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Divide by zero with start held: result stays 0, ready stays high.
    signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    expect_ready_at(2, "dz_hold");
    check("dz_hold_result", result_o, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("dz_hold_ready_held", {63'd0, ready_o}, 64'd1);
      check("dz_hold_result_held", result_o, 64'd0);
    end
    drop_and_check_idle("dz_hold");

    // Normal result held in END while start stays high.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    expect_ready_at(33, "end_hold");
    repeat (3) @(posedge clk);
    #1;
    check("end_hold_ready", {63'd0, ready_o}, 64'd1);
    check("end_hold_result", result_o, {32'd2, 32'd14});
    drop_and_check_idle("end_hold");

    // Annul at iteration 10: edge 1 samples start, iterations begin at edge 2.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_on_ready", {63'd0, ready_o}, 64'd0);
    check("annul_on_result", result_o, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (ready_o === 1'b1) seen = 1'b1;
      end
      check("annul_on_never_ready", {63'd0, seen}, 64'd0);
    end
    v = '{"after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33};
    run_vec(v);

    // Annul in DIVZERO.
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_dz_ready", {63'd0, ready_o}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("annul_dz_ready_later", {63'd0, ready_o}, 64'd0);

    // Annul in IDLE blocks a start; division begins only once annul drops.
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    annul_i = 1'b0;
    expect_ready_at(33, "annul_idle");
    check("annul_idle_result", result_o, {32'd0, 32'd3});
    drop_and_check_idle("annul_idle");

    // Asynchronous reset mid-operation, then restart with start held.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_on_ready", {63'd0, ready_o}, 64'd0);
    check("arst_on_result", result_o, 64'd0);
    @(posedge clk); #1;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    rst = 1'b1;
    expect_ready_at(33, "arst_restart");
    check("arst_restart_result", result_o, {32'd2, 32'd14});

    // Asynchronous reset while a result is held clears outputs without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst_end_ready", {63'd0, ready_o}, 64'd0);
    check("arst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
